// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared defaults and helpers for the scoreboarded register file.
//   - DEF_*      : default widths/counts for reg_file_sb and its scoreboard
//   - idx_width  : register index width derived from the register count
//   - slice_lo   : low bit of port p inside a flattened per-port bus
package reg_file_pkg;

    localparam int DEF_REG_WIDTH = 32;
    localparam int DEF_REG_COUNT = 32;
    localparam int DEF_NUM_RD    = 2;

    function automatic int idx_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   Per-register busy bits. Decode reserves a destination register, and
//   writeback releases it. Register 0 is never busy.
//   Ports:
//     clk, rst        clock, asynchronous active-low reset
//     rsv_en/index    reserve request from decode
//     rsv_ok          the reservation is accepted this cycle
//     wr_en/index     writeback, which clears the busy bit of its register
//     rd_index        flattened lookup indices, one per read port
//     rd_busy         raw busy bit of each looked-up register (no bypass)
//     busy_count      number of busy registers
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int REG_COUNT = DEF_REG_COUNT,
    parameter int IDX_WIDTH = idx_width(REG_COUNT),
    parameter int NUM_RD    = DEF_NUM_RD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rsv_en,
    input  logic [IDX_WIDTH-1:0]        rsv_index,
    output logic                        rsv_ok,
    input  logic                        wr_en,
    input  logic [IDX_WIDTH-1:0]        wr_index,
    input  logic [NUM_RD*IDX_WIDTH-1:0] rd_index,
    output logic [NUM_RD-1:0]           rd_busy,
    output logic [IDX_WIDTH:0]          busy_count
);

    logic [REG_COUNT-1:0] busy, busy_nxt;
    logic                 wr_hit, rsv_set, cnt_inc, cnt_dec;

    always_comb begin
        wr_hit   = wr_en && (wr_index != '0) && busy[wr_index];
        // A write landing this cycle frees the register, so the same cycle
        // may already re-reserve it.
        rsv_ok   = !busy[rsv_index] || (wr_en && (wr_index == rsv_index)) ||
                   (rsv_index == '0);
        rsv_set  = rsv_en && rsv_ok && (rsv_index != '0);
        cnt_inc  = rsv_set && !busy[rsv_index];
        // A release immediately re-reserved leaves the busy bit set, so it
        // must not be counted as a release.
        cnt_dec  = wr_hit && !(rsv_set && (rsv_index == wr_index));
        busy_nxt = busy;
        if (wr_hit)  busy_nxt[wr_index]  = 1'b0;
        if (rsv_set) busy_nxt[rsv_index] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy <= busy_nxt;
            case ({cnt_inc, cnt_dec})
                2'b10:   busy_count <= busy_count + 1'b1;
                2'b01:   busy_count <= busy_count - 1'b1;
                default: busy_count <= busy_count;
            endcase
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_lookup
        localparam int IL = slice_lo(p, IDX_WIDTH);
        assign rd_busy[p] = busy[rd_index[IL +: IDX_WIDTH]];
    end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Multi-port register file with write-to-read bypass and a busy
//   scoreboard. Decode stalls on `hazard`.
//   Ports:
//     clk, rst          clock, asynchronous active-low reset
//     rd_en/index/data  read ports (combinational), flattened per port
//     rd_busy           source register still has a pending write
//     wr_en/index/data  writeback
//     rsv_en/index      reserve a destination register; rsv_ok = accepted
//     hazard            RAW on an enabled read port, or a rejected reservation
//     busy_count        number of busy registers
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int REG_WIDTH = DEF_REG_WIDTH,
    parameter int REG_COUNT = DEF_REG_COUNT,
    parameter int IDX_WIDTH = idx_width(REG_COUNT),
    parameter int NUM_RD    = DEF_NUM_RD,
    parameter int BYPASS    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD-1:0]           rd_en,
    input  logic [NUM_RD*IDX_WIDTH-1:0] rd_index,
    output logic [NUM_RD*REG_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]           rd_busy,
    input  logic                        wr_en,
    input  logic [IDX_WIDTH-1:0]        wr_index,
    input  logic [REG_WIDTH-1:0]        wr_data,
    input  logic                        rsv_en,
    input  logic [IDX_WIDTH-1:0]        rsv_index,
    output logic                        rsv_ok,
    output logic                        hazard,
    output logic [IDX_WIDTH:0]          busy_count
);

    logic [REG_WIDTH-1:0] mem [REG_COUNT];
    logic [NUM_RD-1:0]    sb_busy;
    logic                 wr_live;

    // While reset is asserted, writeback data must not leak through the bypass.
    assign wr_live = wr_en & rst;

    // Entry 0 is never written, so it keeps its reset value of 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
        end else if (wr_en && (wr_index != '0)) begin
            mem[wr_index] <= wr_data;
        end
    end

    reg_file_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .IDX_WIDTH (IDX_WIDTH),
        .NUM_RD    (NUM_RD)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .rsv_en     (rsv_en),
        .rsv_index  (rsv_index),
        .rsv_ok     (rsv_ok),
        .wr_en      (wr_en),
        .wr_index   (wr_index),
        .rd_index   (rd_index),
        .rd_busy    (sb_busy),
        .busy_count (busy_count)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        localparam int IL = slice_lo(p, IDX_WIDTH);
        localparam int DL = slice_lo(p, REG_WIDTH);
        logic [IDX_WIDTH-1:0] idx;
        logic                 fwd;

        assign idx = rd_index[IL +: IDX_WIDTH];
        assign fwd = (BYPASS != 0) && wr_live && (wr_index == idx) && (idx != '0);
        assign rd_data[DL +: REG_WIDTH] = fwd ? wr_data : mem[idx];
        // Forwarded data is the pending write itself, so there is no hazard.
        assign rd_busy[p] = fwd ? 1'b0 : sb_busy[p];
    end

    assign hazard = (|(rd_en & rd_busy)) | (rsv_en & ~rsv_ok);

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single-cycle register file, for the pipelined core.
- Configurable width, depth and read-port count, with write-to-read bypass.
- Per-register busy scoreboard: decode reserves a destination register; writeback releases it.
- Produces a hazard flag so decode can stall on RAW/WAW conflicts. Sits between decode (read and reserve) and writeback (write).

Parameters:
- REG_WIDTH, 32, data bits per register
- REG_COUNT, 32, number of registers (power of two, >= 2)
- IDX_WIDTH, $clog2(REG_COUNT), register index width (derived; not overridden)
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = reads return array contents only

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- rd_en  input  NUM_RD  per-port read valid; qualifies hazard only
- rd_index  input  NUM_RD*IDX_WIDTH  read indices, port p at [p*IDX_WIDTH +: IDX_WIDTH]
- rd_data  output  NUM_RD*REG_WIDTH  read data, port p at [p*REG_WIDTH +: REG_WIDTH]
- rd_busy  output  NUM_RD  per-port: source register has an unresolved pending write
- wr_en  input  1  writeback enable
- wr_index  input  IDX_WIDTH  writeback destination
- wr_data  input  REG_WIDTH  writeback data
- rsv_en  input  1  reserve request from decode
- rsv_index  input  IDX_WIDTH  register to mark busy
- rsv_ok  output  1  reservation will be accepted this cycle
- hazard  output  1  OR over p of (rd_en[p] & rd_busy[p]) | (rsv_en & !rsv_ok)
- busy_count  output  IDX_WIDTH+1  number of registers currently busy

Behaviour:
- Reset (rst low, asynchronous assert, synchronous-safe deassert):
  - All array entries become 0; all busy bits become 0; busy_count becomes 0.
  - While in reset, rd_data is 0, rd_busy is 0, rsv_ok is 1 and hazard is 0.
- Register 0:
  - Reads as 0 and is never busy.
  - Writes and reservations to index 0 are ignored: no state change and no busy_count change; rsv_ok is 1.
- Write: on posedge with wr_en=1 and wr_index!=0, array[wr_index] <= wr_data, and busy[wr_index] clears.
- Read (combinational, zero latency):
  - Base value is array[rd_index].
  - If BYPASS=1 and wr_en=1 and wr_index==rd_index!=0: rd_data = wr_data and rd_busy = 0.
  - Otherwise rd_busy = busy[rd_index].
  - Ports are independent; the same index on several ports is legal.
- Reserve:
  - rsv_ok = !busy[rsv_index] | (wr_en & wr_index==rsv_index) | (rsv_index==0).
  - On posedge with rsv_en & rsv_ok & rsv_index!=0, busy[rsv_index] <= 1.
  - rsv_en with !rsv_ok (WAW on an in-flight register) is dropped: no state change, and hazard is asserted.
- Simultaneous write and reserve to the same nonzero index: the array is written, busy ends at 1 (the new reservation wins), and busy_count is unchanged.
- Write to a register that is not busy: the array updates; busy and busy_count are unchanged (no underflow).
- busy_count update each cycle: +1 on an accepted reservation of a non-busy register, -1 on a write that clears a busy bit, net 0 when both happen. Range is 0..REG_COUNT-1; it never wraps.
- Reset mid-operation: all pending reservations are discarded immediately, with no residual busy bits.

Decomposition:
- Package reg_file_pkg:
  - REG_WIDTH / REG_COUNT / NUM_RD defaults.
  - Derived IDX_WIDTH function.
  - Port-slice helper macros/functions for the flattened buses.
- Sub-module reg_file_scoreboard:
  - Contents: busy bit vector, rsv_ok logic, busy_count counter.
  - Ports: clk, rst, rsv_en/index, wr_en/index, lookup indices, busy outputs.
- The data array and bypass muxing stay in reg_file_sb.

Test Plan:
- Reset: write 0xDEADBEEF to r5, pulse rst low mid-cycle -> r5 reads 0 immediately, busy_count=0, rsv_ok=1, hazard=0.
- r0 protection: wr_en r0=0x1234 and rsv_en r0 -> port0 reading r0 returns 0, rd_busy=0, busy_count stays 0.
- Bypass: BYPASS=1, wr_en r7=0xA5A5A5A5 while port1 reads r7 -> rd_data port1=0xA5A5A5A5 in the same cycle, rd_busy=0. Repeat with BYPASS=0 -> old value (0) returned.
- RAW stall: reserve r3, next cycle rd_en port0 on r3 -> rd_busy[0]=1, hazard=1, busy_count=1. Then write r3=0x55 -> hazard=0 the same cycle (bypass); next cycle port0 reads 0x55 and busy_count=0.
- WAW reject then accept-with-write: reserve r9; reserve r9 again -> rsv_ok=0, hazard=1, busy_count stays 1. Reserve r9 together with a write to r9=0x77 -> rsv_ok=1, busy stays 1, busy_count=1, array r9=0x77.
- Saturation: reserve r1..r31 on consecutive cycles -> busy_count=31. Write all 31 -> busy_count returns to 0. Write the non-busy r4 -> busy_count stays 0.
